urna_booth_arbiter: RTL and testbench

Session controller and round-robin arbiter that shares one vote-tally unit (the `Urna` counter datapath) among `N_BOOTHS` voting booths. It:
- opens and closes the election session;
- enforces one vote per voter per booth;
- serialises booth votes onto the tally unit through a valid/ack handshake.

It sits between the booth keypads and the tally unit and reports session state on `estado`.

---
 rtl/urna_pkg.sv | 22 ++
 rtl/urna_rr_picker.sv | 31 +++
 rtl/urna_booth_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_urna_booth_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/urna_pkg.sv
// Shared definitions for the Urna booth arbiter: session states, default widths
// and the vote-code constants also used by the tally unit.
package urna_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OPEN   = 2'd1,
        S_BUSY   = 2'd2,
        S_CLOSED = 2'd3
    } state_t;

    localparam int DEF_CODE_W = 4;
    localparam int DEF_CNT_W  = 8;

    // One-hot keypad digits voto0..voto3; all-zero is the null vote.
    localparam logic [3:0] VOTO_NULO = 4'b0000;
    localparam logic [3:0] VOTO_A    = 4'b0001;
    localparam logic [3:0] VOTO_B    = 4'b0010;
    localparam logic [3:0] VOTO_C    = 4'b0100;
    localparam logic [3:0] VOTO_D    = 4'b1000;

endpackage

// File: rtl/urna_rr_picker.sv
// Combinational round-robin selector: first set request at or above the pointer,
// wrapping at N, plus a flag telling whether any request is present.
module urna_rr_picker #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] grant,
    output logic           any
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin : pick
        logic [IDW:0] idx;
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = {1'b0, ptr} + (IDW + 1)'(off);
            if (idx >= (IDW + 1)'(N)) begin
                idx = idx - (IDW + 1)'(N);
            end
            if (req[idx[IDW-1:0]]) begin
                grant = idx[IDW-1:0];
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/urna_booth_arbiter.sv
// Session controller and round-robin arbiter sharing one tally unit among booths.
// Optional ack-wait timeout is built only when URNA_ARB_TIMEOUT_EN is defined.
module urna_booth_arbiter
    import urna_pkg::*;
#(
    parameter int N_BOOTHS = 4,
    parameter int CODE_W   = DEF_CODE_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int TIMEOUT  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         open,
    input  logic                         finish,
    input  logic [N_BOOTHS-1:0]          booth_valid,
    input  logic [N_BOOTHS*CODE_W-1:0]   booth_code,
    input  logic [N_BOOTHS-1:0]          booth_swap,
    input  logic                         tally_ack,
    output logic                         tally_valid,
    output logic [CODE_W-1:0]            tally_code,
    output logic [$clog2(N_BOOTHS)-1:0]  grant_id,
    output logic [N_BOOTHS-1:0]          booth_done,
    output logic [1:0]                   estado,
    output logic [CNT_W-1:0]             total_votes,
    output logic                         err_timeout
);

    localparam int IDW = $clog2(N_BOOTHS);

    state_t              state_q, state_d;
    logic [N_BOOTHS-1:0] armed_q, armed_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic                finish_pend_q, finish_pend_d;
    logic                tally_valid_q, tally_valid_d;
    logic [CODE_W-1:0]   tally_code_q, tally_code_d;
    logic [IDW-1:0]      grant_id_q, grant_id_d;
    logic [N_BOOTHS-1:0] booth_done_q, booth_done_d;
    logic [CNT_W-1:0]    total_votes_q, total_votes_d;

    logic [N_BOOTHS-1:0] pick_req;
    logic [IDW-1:0]      pick_id;
    logic                pick_any;
    logic [IDW-1:0]      next_ptr;
    logic [CODE_W-1:0]   codes [N_BOOTHS];

`ifdef URNA_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             err_timeout_q, err_timeout_d;
`endif

    assign pick_req = booth_valid & armed_q;

    urna_rr_picker #(
        .N   (N_BOOTHS),
        .IDW (IDW)
    ) u_picker (
        .req   (pick_req),
        .ptr   (ptr_q),
        .grant (pick_id),
        .any   (pick_any)
    );

    always_comb begin
        for (int i = 0; i < N_BOOTHS; i++) begin
            codes[i] = booth_code[i*CODE_W +: CODE_W];
        end
    end

    assign next_ptr = (grant_id_q == IDW'(N_BOOTHS - 1)) ? '0 : grant_id_q + IDW'(1);

    always_comb begin
        state_d       = state_q;
        armed_d       = armed_q;
        ptr_d         = ptr_q;
        finish_pend_d = finish_pend_q;
        tally_valid_d = tally_valid_q;
        tally_code_d  = tally_code_q;
        grant_id_d    = grant_id_q;
        booth_done_d  = '0;
        total_votes_d = total_votes_q;
`ifdef URNA_ARB_TIMEOUT_EN
        timer_d       = timer_q;
        err_timeout_d = err_timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (open) begin
                    state_d       = S_OPEN;
                    armed_d       = '1;
                    total_votes_d = '0;
                    finish_pend_d = 1'b0;
                end
            end
            S_OPEN: begin
                armed_d = armed_q | booth_swap;
                if (finish) begin
                    state_d = S_CLOSED;
                end else if (pick_any) begin
                    state_d       = S_BUSY;
                    tally_valid_d = 1'b1;
                    tally_code_d  = codes[pick_id];
                    grant_id_d    = pick_id;
`ifdef URNA_ARB_TIMEOUT_EN
                    timer_d       = '0;
`endif
                end
            end
            S_BUSY: begin
                armed_d = armed_q | booth_swap;
                if (finish) begin
                    finish_pend_d = 1'b1;
                end
                // The ack disarm is applied after the swap re-arm so it wins a collision.
                if (tally_ack) begin
                    tally_valid_d            = 1'b0;
                    booth_done_d[grant_id_q] = 1'b1;
                    armed_d[grant_id_q]      = 1'b0;
                    if (total_votes_q != '1) begin
                        total_votes_d = total_votes_q + CNT_W'(1);
                    end
                    ptr_d         = next_ptr;
                    state_d       = (finish_pend_q || finish) ? S_CLOSED : S_OPEN;
                    finish_pend_d = 1'b0;
                end
`ifdef URNA_ARB_TIMEOUT_EN
                else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    tally_valid_d = 1'b0;
                    err_timeout_d = 1'b1;
                    ptr_d         = next_ptr;
                    state_d       = S_OPEN;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
`endif
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            armed_q       <= '0;
            ptr_q         <= '0;
            finish_pend_q <= 1'b0;
            tally_valid_q <= 1'b0;
            tally_code_q  <= '0;
            grant_id_q    <= '0;
            booth_done_q  <= '0;
            total_votes_q <= '0;
        end else begin
            state_q       <= state_d;
            armed_q       <= armed_d;
            ptr_q         <= ptr_d;
            finish_pend_q <= finish_pend_d;
            tally_valid_q <= tally_valid_d;
            tally_code_q  <= tally_code_d;
            grant_id_q    <= grant_id_d;
            booth_done_q  <= booth_done_d;
            total_votes_q <= total_votes_d;
        end
    end

`ifdef URNA_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q       <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            timer_q       <= timer_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign tally_valid = tally_valid_q;
    assign tally_code  = tally_code_q;
    assign grant_id    = grant_id_q;
    assign booth_done  = booth_done_q;
    assign estado      = state_q;
    assign total_votes = total_votes_q;

endmodule

// File: tb/tb_urna_booth_arbiter.sv
// Self-checking bench for urna_booth_arbiter (4 booths, 2-bit vote counter, TIMEOUT=4);
// grants are checked against a scoreboard queue filled when requests are driven.
module tb_urna_booth_arbiter;
    import urna_pkg::*;

    logic        clk;
    logic        rst;
    logic        open;
    logic        finish;
    logic [3:0]  booth_valid;
    logic [15:0] booth_code;
    logic [3:0]  booth_swap;
    logic        tally_ack;
    logic        tally_valid;
    logic [3:0]  tally_code;
    logic [1:0]  grant_id;
    logic [3:0]  booth_done;
    logic [1:0]  estado;
    logic [1:0]  total_votes;
    logic        err_timeout;

    typedef struct {
        logic [1:0] id;
        logic [3:0] code;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_valid = 1'b0;

    urna_booth_arbiter #(
        .N_BOOTHS (4),
        .CODE_W   (4),
        .CNT_W    (2),
        .TIMEOUT  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .open        (open),
        .finish      (finish),
        .booth_valid (booth_valid),
        .booth_code  (booth_code),
        .booth_swap  (booth_swap),
        .tally_ack   (tally_ack),
        .tally_valid (tally_valid),
        .tally_code  (tally_code),
        .grant_id    (grant_id),
        .booth_done  (booth_done),
        .estado      (estado),
        .total_votes (total_votes),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [15:0] codes);
        booth_valid = valid;
        booth_code  = codes;
    endtask

    task automatic expectGrant(input logic [1:0] id, input logic [3:0] code);
        exp_t e;
        e.id   = id;
        e.code = code;
        sb_q.push_back(e);
    endtask

    task automatic ackOnce();
        tally_ack = 1'b1;
        tick();
        tally_ack = 1'b0;
    endtask

    task automatic doVote(input int id, input logic [3:0] code);
        logic [3:0]  v;
        logic [15:0] c;
        v = '0;
        c = '0;
        v[id] = 1'b1;
        c[id*4 +: 4] = code;
        expectGrant(2'(id), code);
        applyStimulus(v, c);
        tick();
        applyStimulus('0, '0);
        checkOutput("vote_valid", 32'(tally_valid), 1);
        ackOnce();
        checkOutput("vote_done", 32'(booth_done), 32'(v));
    endtask

    // Scoreboard: every rising tally_valid must match the oldest expected grant.
    always @(negedge clk) begin
        if (tally_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
                checkOutput("sb_unexpected_grant", 32'(grant_id), 32'hFFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("sb_grant_id", 32'(grant_id), 32'(e.id));
                checkOutput("sb_code", 32'(tally_code), 32'(e.code));
            end
        end
        prev_valid = tally_valid;
    end

    initial begin
        rst = 1'b1; open = 1'b0; finish = 1'b0; tally_ack = 1'b0;
        booth_valid = '0; booth_code = '0; booth_swap = '0;
        tick(); tick();
        checkOutput("rst_estado", 32'(estado), 0);
        checkOutput("rst_valid", 32'(tally_valid), 0);
        checkOutput("rst_code", 32'(tally_code), 0);
        checkOutput("rst_grant", 32'(grant_id), 0);
        checkOutput("rst_done", 32'(booth_done), 0);
        checkOutput("rst_total", 32'(total_votes), 0);
        checkOutput("rst_err", 32'(err_timeout), 0);
        rst = 1'b0;
        applyStimulus(4'b1111, 16'h1111);
        tick(); tick();
        checkOutput("idle_ignores_req", 32'(estado), 0);
        applyStimulus('0, '0);

        // Single vote from booth 1
        open = 1'b1;
        tick();
        open = 1'b0;
        checkOutput("open_estado", 32'(estado), 1);
        expectGrant(2'd1, VOTO_C);
        applyStimulus(4'b0010, 16'h0040);
        tick();
        applyStimulus('0, '0);
        checkOutput("single_latency", 32'(tally_valid), 1);
        checkOutput("single_busy", 32'(estado), 2);
        checkOutput("single_code", 32'(tally_code), 32'(VOTO_C));
        checkOutput("single_grant", 32'(grant_id), 1);
        tick();
        checkOutput("single_hold_valid", 32'(tally_valid), 1);
        checkOutput("single_hold_code", 32'(tally_code), 32'(VOTO_C));
        ackOnce();
        checkOutput("single_ack_valid", 32'(tally_valid), 0);
        checkOutput("single_done", 32'(booth_done), 4'b0010);
        checkOutput("single_total", 32'(total_votes), 1);
        checkOutput("single_reopen", 32'(estado), 1);
        tick();
        checkOutput("single_done_pulse", 32'(booth_done), 0);

        // Round robin: booth 3 brings the pointer back to 0
        doVote(3, VOTO_D);
        checkOutput("rr_total2", 32'(total_votes), 2);
        expectGrant(2'd0, VOTO_A);
        expectGrant(2'd2, VOTO_B);
        applyStimulus(4'b0101, 16'h0201);
        tick();
        checkOutput("rr_first", 32'(grant_id), 0);
        ackOnce();
        checkOutput("rr_done0", 32'(booth_done), 4'b0001);
        tick();
        checkOutput("rr_second_valid", 32'(tally_valid), 1);
        checkOutput("rr_second", 32'(grant_id), 2);
        ackOnce();
        checkOutput("rr_done2", 32'(booth_done), 4'b0100);
        checkOutput("sat_total", 32'(total_votes), 3);
        applyStimulus(4'b0001, 16'h0001);
        repeat (5) tick();
        checkOutput("norearm_valid", 32'(tally_valid), 0);
        checkOutput("norearm_estado", 32'(estado), 1);
        booth_swap = 4'b0001;
        tick();
        booth_swap = '0;
        expectGrant(2'd0, VOTO_A);
        tick();
        applyStimulus('0, '0);
        checkOutput("rearm_valid", 32'(tally_valid), 1);
        checkOutput("rearm_grant", 32'(grant_id), 0);
        ackOnce();
        checkOutput("sat_hold", 32'(total_votes), 3);

        // Swap coinciding with ack leaves the booth disarmed; invalid code forwarded
        booth_swap = 4'b0010;
        tick();
        booth_swap = '0;
        expectGrant(2'd1, 4'b1111);
        applyStimulus(4'b0010, 16'h00F0);
        tick();
        applyStimulus('0, '0);
        checkOutput("col_valid", 32'(tally_valid), 1);
        booth_swap = 4'b0010;
        ackOnce();
        booth_swap = '0;
        checkOutput("col_done", 32'(booth_done), 4'b0010);
        applyStimulus(4'b0010, 16'h00F0);
        repeat (4) tick();
        checkOutput("col_disarmed", 32'(tally_valid), 0);
        applyStimulus('0, '0);

        // Finish while BUSY
        booth_swap = 4'b0100;
        tick();
        booth_swap = '0;
        expectGrant(2'd2, VOTO_NULO);
        applyStimulus(4'b0100, 16'h0000);
        tick();
        applyStimulus('0, '0);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        checkOutput("fin_busy", 32'(estado), 2);
        tick(); tick();
        checkOutput("fin_still_busy", 32'(estado), 2);
        checkOutput("fin_still_valid", 32'(tally_valid), 1);
        ackOnce();
        checkOutput("fin_closed", 32'(estado), 3);
        checkOutput("fin_done", 32'(booth_done), 4'b0100);
        open = 1'b1;
        booth_swap = 4'b1111;
        applyStimulus(4'b1111, 16'h1111);
        repeat (4) tick();
        open = 1'b0;
        booth_swap = '0;
        applyStimulus('0, '0);
        checkOutput("closed_sticky", 32'(estado), 3);
        checkOutput("closed_no_grant", 32'(tally_valid), 0);
        checkOutput("closed_total", 32'(total_votes), 3);

        // Reset in the middle of BUSY
        rst = 1'b1;
        tick();
        rst = 1'b0;
        open = 1'b1;
        tick();
        open = 1'b0;
        expectGrant(2'd3, VOTO_D);
        applyStimulus(4'b1000, 16'h8000);
        tick();
        applyStimulus('0, '0);
        checkOutput("rb_valid", 32'(tally_valid), 1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rb_valid_async", 32'(tally_valid), 0);
        checkOutput("rb_estado", 32'(estado), 0);
        checkOutput("rb_code", 32'(tally_code), 0);
        checkOutput("rb_grant", 32'(grant_id), 0);
        tick();
        rst = 1'b0;

        // Withheld ack
        open = 1'b1;
        tick();
        open = 1'b0;
        expectGrant(2'd1, VOTO_B);
        applyStimulus(4'b0010, 16'h0020);
        tick();
        applyStimulus('0, '0);
`ifdef URNA_ARB_TIMEOUT_EN
        repeat (3) tick();
        checkOutput("to_wait_valid", 32'(tally_valid), 1);
        checkOutput("to_wait_err", 32'(err_timeout), 0);
        tick();
        checkOutput("to_valid", 32'(tally_valid), 0);
        checkOutput("to_err", 32'(err_timeout), 1);
        checkOutput("to_estado", 32'(estado), 1);
        checkOutput("to_no_done", 32'(booth_done), 0);
        checkOutput("to_total", 32'(total_votes), 0);
        expectGrant(2'd1, VOTO_B);
        applyStimulus(4'b0010, 16'h0020);
        tick();
        applyStimulus('0, '0);
        checkOutput("to_rearmed", 32'(tally_valid), 1);
        ackOnce();
        checkOutput("to_err_sticky", 32'(err_timeout), 1);
        checkOutput("to_total_after", 32'(total_votes), 1);
`else
        repeat (20) tick();
        checkOutput("wait_valid", 32'(tally_valid), 1);
        checkOutput("wait_estado", 32'(estado), 2);
        checkOutput("wait_err", 32'(err_timeout), 0);
        ackOnce();
        checkOutput("wait_done", 32'(booth_done), 4'b0010);
        checkOutput("wait_total", 32'(total_votes), 1);
`endif
        tick();
        checkOutput("sb_drained", 32'(sb_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
